tube_scroller: RTL and testbench

//  Generates position/size of the 4 tube pairs (bottom tub_* and upper tub_*_U) fed to the per-pixel

---
 rtl/tube_scroller.sv | 144 ++++++++++++++
 tb/tb_tube_scroller.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/tube_scroller.sv
// Tube pair scroller: four tube pairs scroll left on a wrapped field, re-roll gap
// height from an LFSR on wrap, and pulse score_pulse when a pair crosses the player column.
module tube_scroller #(
  parameter int unsigned FIELD_W      = 850,
  parameter int unsigned SCREEN_H     = 480,
  parameter int unsigned TUB_W        = 60,
  parameter int unsigned SPACING      = 212,
  parameter int unsigned INIT_X       = 640,
  parameter int unsigned INIT_GAP_TOP = 170,
  parameter int unsigned GAP_TOP_MIN  = 40,
  parameter int unsigned GAP          = 140,
  parameter int unsigned BIRD_X       = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        start,
  input  logic        hit,
  input  logic [2:0]  speed,
  output logic [19:0] tub_loc_0,
  output logic [19:0] tub_loc_1,
  output logic [19:0] tub_loc_2,
  output logic [19:0] tub_loc_3,
  output logic [19:0] tub_size_0,
  output logic [19:0] tub_size_1,
  output logic [19:0] tub_size_2,
  output logic [19:0] tub_size_3,
  output logic [19:0] tub_loc_0_U,
  output logic [19:0] tub_loc_1_U,
  output logic [19:0] tub_loc_2_U,
  output logic [19:0] tub_loc_3_U,
  output logic [19:0] tub_size_0_U,
  output logic [19:0] tub_size_1_U,
  output logic [19:0] tub_size_2_U,
  output logic [19:0] tub_size_3_U,
  output logic        running,
  output logic        score_pulse
);

  localparam logic [9:0] FIELD_W10  = 10'(FIELD_W);
  localparam logic [9:0] SCREEN_H10 = 10'(SCREEN_H);
  localparam logic [9:0] TUB_W10    = 10'(TUB_W);
  localparam logic [9:0] GAP_TOP0   = 10'(INIT_GAP_TOP);
  localparam logic [9:0] GAP_MIN10  = 10'(GAP_TOP_MIN);
  localparam logic [9:0] GAP10      = 10'(GAP);
  localparam logic [9:0] BIRD_X10   = 10'(BIRD_X);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t      state, state_nxt;
  logic [9:0]  x     [4];
  logic [9:0]  gap   [4];
  logic [9:0]  bot_y [4];
  logic [9:0]  bot_h [4];
  logic [7:0]  roll  [4];
  logic [15:0] lfsr;
  logic [9:0]  spd;
  logic        load, move, pass;

  function automatic logic [9:0] load_x(input int unsigned i);
    return 10'((INIT_X + i * SPACING) % FIELD_W);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (hit)   state_nxt = STOP;
      STOP:    if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    running = (state == RUN);
    load    = (state == STOP) && start;
    move    = (state == RUN) && frame_tick && !hit && (speed != '0);
  end

  // Each pair takes a different byte-rotation of the same LFSR so simultaneous wraps differ.
  always_comb begin
    spd     = {7'd0, speed};
    pass    = 1'b0;
    roll[0] = lfsr[7:0];
    roll[1] = lfsr[15:8];
    roll[2] = {lfsr[3:0], lfsr[15:12]};
    roll[3] = lfsr[11:4];
    for (int unsigned i = 0; i < 4; i++) begin
      if (x[i] >= BIRD_X10 && (x[i] - spd) < BIRD_X10) pass = 1'b1;
      bot_y[i] = gap[i] + GAP10;
      bot_h[i] = SCREEN_H10 - bot_y[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr        <= 16'hACE1;
      score_pulse <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
        x[i]   <= load_x(i);
        gap[i] <= GAP_TOP0;
      end
    end else begin
      lfsr        <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      score_pulse <= move && pass;
      for (int unsigned i = 0; i < 4; i++) begin
        if (load) begin
          x[i]   <= load_x(i);
          gap[i] <= GAP_TOP0;
        end else if (move) begin
          if (x[i] >= spd) begin
            x[i] <= x[i] - spd;
          end else begin
            x[i]   <= x[i] + FIELD_W10 - spd;
            gap[i] <= GAP_MIN10 + {2'd0, roll[i]};
          end
        end
      end
    end
  end

  assign tub_loc_0    = {x[0], bot_y[0]};
  assign tub_loc_1    = {x[1], bot_y[1]};
  assign tub_loc_2    = {x[2], bot_y[2]};
  assign tub_loc_3    = {x[3], bot_y[3]};
  assign tub_size_0   = {TUB_W10, bot_h[0]};
  assign tub_size_1   = {TUB_W10, bot_h[1]};
  assign tub_size_2   = {TUB_W10, bot_h[2]};
  assign tub_size_3   = {TUB_W10, bot_h[3]};
  assign tub_loc_0_U  = {x[0], 10'd0};
  assign tub_loc_1_U  = {x[1], 10'd0};
  assign tub_loc_2_U  = {x[2], 10'd0};
  assign tub_loc_3_U  = {x[3], 10'd0};
  assign tub_size_0_U = {TUB_W10, gap[0]};
  assign tub_size_1_U = {TUB_W10, gap[1]};
  assign tub_size_2_U = {TUB_W10, gap[2]};
  assign tub_size_3_U = {TUB_W10, gap[3]};

endmodule

// File: tb/tb_tube_scroller.sv
// Directed bench for tube_scroller with a small reference model of positions, gaps and LFSR.
module tb_tube_scroller;

  logic        clk = 1'b0;
  logic        rst, frame_tick, start, hit;
  logic [2:0]  speed;
  logic [19:0] tub_loc_0, tub_loc_1, tub_loc_2, tub_loc_3;
  logic [19:0] tub_size_0, tub_size_1, tub_size_2, tub_size_3;
  logic [19:0] tub_loc_0_U, tub_loc_1_U, tub_loc_2_U, tub_loc_3_U;
  logic [19:0] tub_size_0_U, tub_size_1_U, tub_size_2_U, tub_size_3_U;
  logic        running, score_pulse;

  tube_scroller dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start), .hit(hit), .speed(speed),
    .tub_loc_0(tub_loc_0), .tub_loc_1(tub_loc_1), .tub_loc_2(tub_loc_2), .tub_loc_3(tub_loc_3),
    .tub_size_0(tub_size_0), .tub_size_1(tub_size_1), .tub_size_2(tub_size_2), .tub_size_3(tub_size_3),
    .tub_loc_0_U(tub_loc_0_U), .tub_loc_1_U(tub_loc_1_U), .tub_loc_2_U(tub_loc_2_U), .tub_loc_3_U(tub_loc_3_U),
    .tub_size_0_U(tub_size_0_U), .tub_size_1_U(tub_size_1_U), .tub_size_2_U(tub_size_2_U),
    .tub_size_3_U(tub_size_3_U), .running(running), .score_pulse(score_pulse)
  );

  always #5 clk = ~clk;

  logic [19:0] loc [4], size [4], loc_u [4], size_u [4];
  assign loc[0] = tub_loc_0;   assign loc[1] = tub_loc_1;   assign loc[2] = tub_loc_2;   assign loc[3] = tub_loc_3;
  assign size[0] = tub_size_0; assign size[1] = tub_size_1; assign size[2] = tub_size_2; assign size[3] = tub_size_3;
  assign loc_u[0] = tub_loc_0_U;   assign loc_u[1] = tub_loc_1_U;
  assign loc_u[2] = tub_loc_2_U;   assign loc_u[3] = tub_loc_3_U;
  assign size_u[0] = tub_size_0_U; assign size_u[1] = tub_size_1_U;
  assign size_u[2] = tub_size_2_U; assign size_u[3] = tub_size_3_U;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference LFSR: Fibonacci, taps 16,14,13,11, seed ACE1, steps every clock.
  logic [15:0] lfsr_m;
  always @(posedge clk or posedge rst) begin
    if (rst) lfsr_m <= 16'hACE1;
    else     lfsr_m <= {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
  end

  int unsigned mx [4];
  int unsigned mg [4];
  int          m_state;  // 0 idle, 1 run, 2 stop
  bit          m_pulse;
  logic [15:0] l_used;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic model_load();
    mx[0] = 640; mx[1] = 2; mx[2] = 214; mx[3] = 426;
    for (int i = 0; i < 4; i++) mg[i] = 170;
  endtask

  task automatic check_all(input string tag);
    logic [19:0] e;
    for (int i = 0; i < 4; i++) begin
      e = {10'(mx[i]), 10'(mg[i] + 140)};
      check($sformatf("%s loc%0d", tag, i), {12'd0, loc[i]}, {12'd0, e});
      e = {10'd60, 10'(480 - (mg[i] + 140))};
      check($sformatf("%s size%0d", tag, i), {12'd0, size[i]}, {12'd0, e});
      e = {10'(mx[i]), 10'd0};
      check($sformatf("%s loc%0d_U", tag, i), {12'd0, loc_u[i]}, {12'd0, e});
      e = {10'd60, 10'(mg[i])};
      check($sformatf("%s size%0d_U", tag, i), {12'd0, size_u[i]}, {12'd0, e});
    end
    check($sformatf("%s running", tag), {31'd0, running}, {31'd0, m_state == 1});
  endtask

  task automatic do_tick(input string tag, input logic [2:0] spd, input logic h);
    logic [7:0] r;
    @(negedge clk);
    speed = spd; frame_tick = 1'b1; hit = h;
    l_used  = lfsr_m;
    m_pulse = 1'b0;
    if (m_state == 1 && h) begin
      m_state = 2;
    end else if (m_state == 1 && spd != 0) begin
      for (int i = 0; i < 4; i++) begin
        if (mx[i] >= spd) begin
          if (mx[i] >= 100 && mx[i] - spd < 100) m_pulse = 1'b1;
          mx[i] = mx[i] - spd;
        end else begin
          case (i)
            0:       r = l_used[7:0];
            1:       r = l_used[15:8];
            2:       r = {l_used[3:0], l_used[15:12]};
            default: r = l_used[11:4];
          endcase
          mx[i] = mx[i] + 850 - spd;
          mg[i] = 40 + r;
        end
      end
    end
    @(negedge clk);
    frame_tick = 1'b0; hit = 1'b0;
    check_all(tag);
    check({tag, " pulse"}, {31'd0, score_pulse}, {31'd0, m_pulse});
    @(negedge clk);
    check({tag, " pulse_drop"}, {31'd0, score_pulse}, 32'd0);
  endtask

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    if (m_state == 0) m_state = 1;
    else if (m_state == 2) begin model_load(); m_state = 1; end
    @(negedge clk); start = 1'b0;
  endtask

  task automatic do_hit();
    @(negedge clk); hit = 1'b1;
    if (m_state == 1) m_state = 2;
    @(negedge clk); hit = 1'b0;
  endtask

  initial begin
    rst = 1'b1; frame_tick = 1'b0; start = 1'b0; hit = 1'b0; speed = 3'd0;
    model_load(); m_state = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst loc0", {12'd0, tub_loc_0}, {12'd0, 10'd640, 10'd310});
    check("rst size0", {12'd0, tub_size_0}, {12'd0, 10'd60, 10'd170});
    check("rst loc1_U", {12'd0, tub_loc_1_U}, {12'd0, 10'd2, 10'd0});
    check("rst running", {31'd0, running}, 32'd0);
    check("rst pulse", {31'd0, score_pulse}, 32'd0);
    check_all("rst");

    do_hit();
    check("idle hit ignored", {31'd0, running}, 32'd0);
    do_tick("idle tick", 3'd2, 1'b0);

    do_start();
    check("start running", {31'd0, running}, 32'd1);

    do_tick("move1", 3'd2, 1'b0);
    check("move1 x0", {22'd0, tub_loc_0[19:10]}, 32'd638);
    check("move1 x1", {22'd0, tub_loc_1_U[19:10]}, 32'd0);
    check("move1 size0", {12'd0, tub_size_0}, {12'd0, 10'd60, 10'd170});

    do_tick("wrap", 3'd2, 1'b0);
    check("wrap x1", {22'd0, tub_loc_1_U[19:10]}, 32'd848);
    check("wrap gap1", {22'd0, tub_size_1_U[9:0]}, 32'd40 + {24'd0, l_used[15:8]});

    for (int k = 0; k < 15; k++) do_tick("run7", 3'd7, 1'b0);
    do_tick("run4", 3'd4, 1'b0);
    check("pre score x2", {22'd0, tub_loc_2[19:10]}, 32'd101);
    do_tick("score", 3'd3, 1'b0);
    check("score x2", {22'd0, tub_loc_2[19:10]}, 32'd98);

    for (int k = 0; k < 30; k++) do_tick("run7b", 3'd7, 1'b0);
    check("at bird x3", {22'd0, tub_loc_3[19:10]}, 32'd100);
    do_tick("speed0", 3'd0, 1'b0);
    check("speed0 x3", {22'd0, tub_loc_3[19:10]}, 32'd100);

    do_start();
    check_all("run start ignored");

    do_tick("hit tick", 3'd3, 1'b1);
    check("hit running", {31'd0, running}, 32'd0);
    do_tick("stop tick a", 3'd5, 1'b0);
    do_tick("stop tick b", 3'd7, 1'b0);

    do_start();
    check_all("restart");
    check("restart x0", {22'd0, tub_loc_0[19:10]}, 32'd640);

    do_tick("rerun a", 3'd6, 1'b0);
    do_tick("rerun b", 3'd6, 1'b0);

    @(negedge clk);
    rst = 1'b1;
    #2;
    model_load(); m_state = 0;
    check_all("async rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("post rst pulse", {31'd0, score_pulse}, 32'd0);
    end
    check_all("post rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
